// File: rtl/pwm_pkg.sv
// Shared state encoding and reset defaults for the PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    // Reset fill bits: period defaults to all ones, duty to all zeros.
    localparam logic PERIOD_RST_BIT = 1'b1;
    localparam logic DUTY_RST_BIT   = 1'b0;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow config register with pending flag; accepts one config until the FSM loads it.
module pwm_shadow_reg
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic             load,
    output logic             cfg_ready,
    output logic             pending,
    output logic [WIDTH-1:0] shadow_period,
    output logic [WIDTH-1:0] shadow_duty
);

    logic             pending_q, pending_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;

    // load is only raised while pending, so it never coincides with a transfer.
    always_comb begin
        pending_d   = pending_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        if (cfg_valid && !pending_q) begin
            pending_d   = 1'b1;
            period_sh_d = cfg_period;
            duty_sh_d   = cfg_duty;
        end else if (load) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q   <= 1'b0;
            period_sh_q <= {WIDTH{PERIOD_RST_BIT}};
            duty_sh_q   <= {WIDTH{DUTY_RST_BIT}};
        end else begin
            pending_q   <= pending_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
        end
    end

    assign cfg_ready     = !pending_q;
    assign pending       = pending_q;
    assign shadow_period = period_sh_q;
    assign shadow_duty   = duty_sh_q;

endmodule

// File: rtl/pwm_gen.sv
// Programmable PWM / period timer with glitch-free config update at period boundaries.
// Optional sticky period interrupt is enabled by defining PWM_IRQ_EN.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] cnt,
    output logic             pwm_out,
    output logic             period_tick,
`ifdef PWM_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pending;
    logic             load;
    logic             wrap;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;

    pwm_shadow_reg #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .load         (load),
        .cfg_ready    (cfg_ready),
        .pending      (pending),
        .shadow_period(shadow_period),
        .shadow_duty  (shadow_duty)
    );

    assign wrap = (cnt_q == period_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        duty_d   = duty_q;
        load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = pending;
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                load  = pending && wrap;
                if (!en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                load  = pending && wrap;
                if (en) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            period_d = shadow_period;
            duty_d   = shadow_duty;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= {WIDTH{PERIOD_RST_BIT}};
            duty_q   <= {WIDTH{DUTY_RST_BIT}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            duty_q   <= duty_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign cnt         = cnt_q;
    assign pwm_out     = busy && (cnt_q < duty_q);
    assign period_tick = busy && wrap;

`ifdef PWM_IRQ_EN
    logic irq_q, irq_d;

    // Set wins over clear so a tick is never lost.
    always_comb begin
        irq_d = irq_q;
        if (period_tick) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
